instr_mem_loader: RTL
=====================

# instr_mem_loader

Program loader that fills the instruction memory from a byte stream before the core runs. It accepts a framed byte stream: a 16-bit word count, that many 32-bit instructions as little-endian bytes, then an XOR checksum byte. It assembles each instruction and issues one write per word on the instruction memory's write port, at byte addresses 0, 4, 8, and so on. It holds the core in `Cpu_Hold` until the image is complete and verified.

## Interface
Parameters:
- `DEPTH`, 32: number of instruction words the memory holds; a count above this is rejected.

Ports (one clock; reset is synchronous and active-high):
- `Clock`  in  1  rising-edge clock.
- `Reset`  in  1  synchronous, active-high reset.
- `Start`  in  1  single-cycle request to begin a load.
- `Byte_In`  in  8  stream byte.
- `Byte_Valid`  in  1  `Byte_In` is valid.
- `Byte_Ready`  out  1  loader can accept a byte this cycle.
- `Mem_Write_Enable`  out  1  one-cycle write strobe to instruction memory.
- `Mem_Write_Address`  out  32  byte address, always word-aligned (word_index*4).
- `Mem_Write_Data`  out  32  assembled instruction.
- `Cpu_Hold`  out  1  keeps the core stalled or reset.
- `Load_Done`  out  1  level; image loaded and checksum matched.
- `Load_Error`  out  1  level; count exceeded `DEPTH` or checksum mismatched.
- `Words_Loaded`  out  16  number of words written so far in the current load.

## Operation
- States and outputs:
  - `IDLE`: `Byte_Ready`=0, `Cpu_Hold`=0.
  - `COUNT_LO`, `COUNT_HI`, `DATA`, `CHECK`: `Byte_Ready`=1, `Cpu_Hold`=1.
  - `DONE`: `Load_Done`=1, `Cpu_Hold`=0.
  - `ERROR`: `Load_Error`=1, `Cpu_Hold`=1. The core is never released onto a partial image.
- A byte is accepted on a rising edge where `Byte_Valid` and `Byte_Ready` are both 1.
- `IDLE`, `DONE` or `ERROR`, with `Start`=1: clear `Load_Done`, `Load_Error`, `Words_Loaded`, the checksum accumulator and the byte index, then go to `COUNT_LO`.
- `Start` is ignored in every other state.
- `COUNT_LO`: on accept, latch count[7:0] and go to `COUNT_HI`.
- `COUNT_HI`: on accept, latch count[15:8]. Then:
  - count > `DEPTH`: go to `ERROR`.
  - count = 0: go to `CHECK`.
  - otherwise: go to `DATA`.
- `DATA`:
  - Each accepted byte is XORed into the checksum.
  - Byte k of the current word goes to bits [8k+7:8k] (little-endian).
  - On the 4th byte, register `Mem_Write_Data`, `Mem_Write_Address`=`Words_Loaded`*4, and `Mem_Write_Enable`=1 for the following cycle. `Words_Loaded` increments on that same edge.
  - After the 4th byte of word count-1, go to `CHECK`.
- `CHECK`: on accept, compare `Byte_In` with the checksum. Match: go to `DONE`. Mismatch: go to `ERROR`.
- Count bytes and the checksum byte are excluded from the checksum.
- Byte index (2-bit) and word index wrap cleanly: no word is written until all 4 bytes have arrived.

## Timing
- Reset values: state `IDLE`; all outputs 0 (`Byte_Ready`, `Mem_Write_Enable`, `Mem_Write_Address`, `Mem_Write_Data`, `Cpu_Hold`, `Load_Done`, `Load_Error`, `Words_Loaded`).
- Throughput is 1 byte per cycle. `Byte_Ready` stays high during a write cycle, because the assembly register is separate from the `Mem_Write_Data` register.
- Write latency: 4th byte accepted at edge N; `Mem_Write_Enable`=1 between edges N and N+1, so memory samples it at edge N+1. The strobe is never wider than one cycle.
- The last word's write strobe occurs during the first `CHECK` cycle.
- `Load_Done` / `Load_Error` rise 1 cycle after the deciding byte is accepted. They hold until `Start` or `Reset`.
- `Cpu_Hold` rises the cycle after `Start` and falls the cycle after the matching checksum byte is accepted.
- Gaps in `Byte_Valid` stall the FSM with no state change. `Start` and `Byte_Valid` in the same `IDLE` cycle: the byte is not accepted.
- `Reset` mid-load: next cycle is `IDLE` with all outputs 0, no further writes, and a pending write strobe is cancelled.
- `Reset` and `Start` asserted together: `Reset` wins.

## Test plan
- **Reset:** assert `Reset` 2 cycles with random inputs -> every output 0, `Byte_Ready`=0.
- **Good 2-word load:** `Start`; bytes 02 00, 13 05 00 00, 93 05 10 00, checksum 90 ->
  - writes (addr 0x0, data 0x00000513) then (addr 0x4, data 0x00100593), each 1-cycle strobe;
  - `Words_Loaded`=2, `Load_Done`=1, `Cpu_Hold`=0.
- **Bad checksum:** same stream with checksum 91 -> both writes occur, then `Load_Error`=1, `Load_Done`=0, `Cpu_Hold`=1. A following `Start` clears `Load_Error`.
- **Oversize count:** `DEPTH`=32, count bytes 21 00 -> `Load_Error`=1 one cycle after the 2nd byte, zero writes, `Byte_Ready`=0.
- **Zero count:** bytes 00 00 00 -> `Load_Done`=1, no write strobes, `Words_Loaded`=0.
- **Stall and interrupt:**
  - Good 2-word load with random `Byte_Valid` gaps -> identical writes and result.
  - Separate run with `Reset` after 6 data bytes -> exactly one write (addr 0x0), then all outputs 0 and no further strobes.

Source files
------------

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: receives a framed byte stream (16-bit word count, count
// little-endian 32-bit instructions, XOR checksum byte). It writes each
// instruction to the instruction memory at byte address word_index*4. The
// core is held until the whole image has arrived and the checksum matches.
module instr_mem_loader #(
  parameter int DEPTH = 32
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [7:0]  Byte_In,
  input  logic        Byte_Valid,
  output logic        Byte_Ready,
  output logic        Mem_Write_Enable,
  output logic [31:0] Mem_Write_Address,
  output logic [31:0] Mem_Write_Data,
  output logic        Cpu_Hold,
  output logic        Load_Done,
  output logic        Load_Error,
  output logic [15:0] Words_Loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT_LO,
    S_COUNT_HI,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_e;

  localparam logic [15:0] DepthW = 16'(DEPTH);

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] asm_q, asm_d;        // partial word; only bytes 0..2 are ever used
  logic [7:0]  csum_q, csum_d;
  logic [15:0] words_q, words_d;
  logic        we_q, we_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        accept;
  logic [15:0] count_full;

  // State register and datapath registers; Reset wins over any other input.
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (Reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      byte_idx_q <= '0;
      asm_q      <= '0;
      csum_q     <= '0;
      words_q    <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      csum_q     <= csum_d;
      words_q    <= words_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Next-state logic: frame parsing, word assembly and write issue.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    count_d    = count_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    csum_d     = csum_q;
    words_d    = words_q;
    we_d       = 1'b0;           // the strobe is never held past one cycle
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    count_full = {Byte_In, count_q[7:0]};
    accept     = Byte_Valid && Byte_Ready;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (Start) begin
          words_d    = '0;
          csum_d     = '0;
          byte_idx_d = '0;
          state_d    = S_COUNT_LO;
        end
      end
      S_COUNT_LO: begin
        if (accept) begin
          count_d[7:0] = Byte_In;
          state_d      = S_COUNT_HI;
        end
      end
      S_COUNT_HI: begin
        if (accept) begin
          count_d[15:8] = Byte_In;
          if (count_full > DepthW)       state_d = S_ERROR;
          else if (count_full == 16'd0)  state_d = S_CHECK;
          else                           state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          csum_d     = csum_q ^ Byte_In;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            // Completed word goes to its own register, so assembly of the
            // next word can continue while the write is in flight.
            wdata_d = {Byte_In, asm_q[23:0]};
            waddr_d = {14'd0, words_q, 2'b00};
            we_d    = 1'b1;
            words_d = words_q + 16'd1;
            if (words_q + 16'd1 == count_q) state_d = S_CHECK;
          end else begin
            asm_d[{byte_idx_q, 3'b000} +: 8] = Byte_In;
          end
        end
      end
      S_CHECK: begin
        if (accept) state_d = (Byte_In == csum_q) ? S_DONE : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decode directly from the state register.
  always_comb begin
    Byte_Ready = (state_q == S_COUNT_LO) || (state_q == S_COUNT_HI) ||
                 (state_q == S_DATA)     || (state_q == S_CHECK);
    Cpu_Hold   = Byte_Ready || (state_q == S_ERROR);
    Load_Done  = (state_q == S_DONE);
    Load_Error = (state_q == S_ERROR);
  end

  assign Mem_Write_Enable  = we_q;
  assign Mem_Write_Address = waddr_q;
  assign Mem_Write_Data    = wdata_q;
  assign Words_Loaded      = words_q;

endmodule
